// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared ALU mode codes, status flag bit positions and arbiter FSM states
package alu_arb_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_ADC  = 4'b0010;
  localparam logic [3:0] ALU_SBB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOT  = 4'b0111;
  localparam logic [3:0] ALU_SHL  = 4'b1000;
  localparam logic [3:0] ALU_SHR  = 4'b1001;
  localparam logic [3:0] ALU_ROL  = 4'b1010;
  localparam logic [3:0] ALU_ROR  = 4'b1011;
  localparam logic [3:0] ALU_INC  = 4'b1100;
  localparam logic [3:0] ALU_DEC  = 4'b1101;
  localparam logic [3:0] ALU_PASS = 4'b1110;
  localparam logic [3:0] ALU_NEG  = 4'b1111;
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_S = 1;
  localparam int FLG_O = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;
endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid requester at or after the pointer
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);
  logic [IW-1:0] w_j;
  // walk offsets from farthest to nearest so the closest valid requester wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (i_valid[w_j]) begin
        o_grant = N'(1) << w_j;
        o_idx   = w_j;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU with status register; ALU_ARB_LOCK_EN adds grant locking
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int MW   = 4,
  parameter int FW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*MW-1:0] req_mode,
  input  logic [NREQ*DW-1:0] req_op1,
  input  logic [NREQ*DW-1:0] req_op2,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]  req_lock,
`endif
  output logic [NREQ-1:0]  rsp_valid,
  input  logic [NREQ-1:0]  rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic [FW-1:0]    rsp_flags,
  output logic             alu_E,
  output logic [MW-1:0]    alu_Mode,
  output logic [DW-1:0]    alu_Operand1,
  output logic [DW-1:0]    alu_Operand2,
  output logic [FW-1:0]    alu_Cflags,
  input  logic [DW-1:0]    alu_Out,
  input  logic [FW-1:0]    alu_flags,
  output logic [FW-1:0]    sr_flags
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t          r_state, w_next;
  logic [IW-1:0]   r_ptr, r_owner, w_idx, w_base, w_ptr_inc;
  logic [NREQ-1:0] w_grant;
  logic            w_acc;
  logic [MW-1:0]   r_mode;
  logic [DW-1:0]   r_op1, r_op2, r_data;
  logic [FW-1:0]   r_flags, r_sr;
`ifdef ALU_ARB_LOCK_EN
  logic            r_lock;
  assign w_base = r_lock ? r_owner : r_ptr;
`else
  assign w_base = r_ptr;
`endif
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .i_valid(req_valid),
    .i_ptr  (w_base),
    .o_grant(w_grant),
    .o_idx  (w_idx)
  );
  assign w_acc        = (r_state == ST_IDLE) && (|w_grant);
  assign w_ptr_inc    = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
  assign req_ready    = (r_state == ST_IDLE) ? w_grant : '0;
  assign rsp_valid    = (r_state == ST_RESP) ? NREQ'(1) << r_owner : '0;
  assign alu_E        = r_state == ST_ISSUE;
  assign alu_Mode     = r_mode;
  assign alu_Operand1 = r_op1;
  assign alu_Operand2 = r_op2;
  assign alu_Cflags   = r_sr;
  assign sr_flags     = r_sr;
  assign rsp_data     = r_data;
  assign rsp_flags    = r_flags;
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  // next state: accept in IDLE, one ISSUE cycle, hold RESP until the owner consumes
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = w_acc ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: w_next = ST_RESP;
      ST_RESP:  w_next = rsp_ready[r_owner] ? ST_IDLE : ST_RESP;
      default:  w_next = ST_IDLE;
    endcase
  end
  // operand latch on accept, result and status capture at the end of ISSUE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_mode  <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_data  <= '0;
      r_flags <= '0;
      r_sr    <= '0;
`ifdef ALU_ARB_LOCK_EN
      r_lock  <= 1'b0;
`endif
    end else begin
      if (w_acc) begin
        r_mode  <= req_mode[w_idx*MW +: MW];
        r_op1   <= req_op1[w_idx*DW +: DW];
        r_op2   <= req_op2[w_idx*DW +: DW];
        r_owner <= w_idx;
`ifdef ALU_ARB_LOCK_EN
        r_lock  <= req_lock[w_idx];
        r_ptr   <= req_lock[w_idx] ? r_ptr : w_ptr_inc;
`else
        r_ptr   <= w_ptr_inc;
`endif
      end
      if (r_state == ST_ISSUE) begin
        r_data  <= alu_Out;
        r_flags <= alu_flags;
        r_sr    <= alu_flags;
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU; lock test follows ALU_ARB_LOCK_EN
module tb_alu_arbiter;
  import alu_arb_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_lock = '0;
  logic [3:0]  rsp_ready = 4'hF;
  logic [15:0] req_mode = '0;
  logic [31:0] req_op1 = '0;
  logic [31:0] req_op2 = '0;
  logic [3:0]  req_ready, rsp_valid, rsp_flags, alu_Mode, alu_Cflags, alu_flags, sr_flags;
  logic [7:0]  rsp_data, alu_Operand1, alu_Operand2, alu_Out;
  logic        alu_E;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [3:0]  sr_exp = '0;
  typedef struct {
    logic [3:0] own;
    logic [7:0] d;
    logic [3:0] f;
  } exp_t;
  exp_t sb[$];

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_op1(req_op1), .req_op2(req_op2),
`ifdef ALU_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .alu_E(alu_E), .alu_Mode(alu_Mode),
    .alu_Operand1(alu_Operand1), .alu_Operand2(alu_Operand2),
    .alu_Cflags(alu_Cflags), .alu_Out(alu_Out), .alu_flags(alu_flags),
    .sr_flags(sr_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural ALU returning {Z,C,S,O, result}
  function automatic logic [11:0] alu_f(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b, input logic [3:0] cf);
    logic [8:0] s;
    logic [7:0] r;
    logic c, o;
    s = '0; c = 1'b0; o = 1'b0;
    case (m)
      ALU_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
      ALU_ADC: begin s = {1'b0, a} + {1'b0, b} + {8'd0, cf[FLG_C]}; r = s[7:0]; c = s[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
      ALU_SUB: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; r = s[7:0]; c = s[8]; o = (a[7] != b[7]) && (r[7] != a[7]); end
      ALU_AND: r = a & b;
      ALU_XOR: r = a ^ b;
      default: r = a;
    endcase
    return {r == 8'd0, c, r[7], o, r};
  endfunction

  assign {alu_flags, alu_Out} = alu_f(alu_Mode, alu_Operand1, alu_Operand2, alu_Cflags);

  task automatic set_req(input int i, input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
    req_mode[i*4 +: 4] = m;
    req_op1[i*8 +: 8]  = a;
    req_op2[i*8 +: 8]  = b;
    req_valid[i]       = 1'b1;
  endtask

  // scoreboard: push expected result at accept, pop and compare at response handshake
  always @(negedge clk) begin
    exp_t e;
    logic [11:0] r;
    if (rst_n) begin
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) begin
          r = alu_f(req_mode[i*4 +: 4], req_op1[i*8 +: 8], req_op2[i*8 +: 8], sr_exp);
          sr_exp = r[11:8];
          e.own = 4'b1 << i;
          e.d = r[7:0];
          e.f = r[11:8];
          sb.push_back(e);
        end
      if ((rsp_valid & rsp_ready) != 4'b0) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: rsp_valid=%b with no operation outstanding", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== e.own || rsp_data !== e.d || rsp_flags !== e.f || sr_flags !== e.f) begin
            n_err++;
            $display("FAIL sb_result: got valid=%b data=%h flags=%b sr=%b, expected valid=%b data=%h flags=%b",
                     rsp_valid, rsp_data, rsp_flags, sr_flags, e.own, e.d, e.f);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({req_ready, rsp_valid, alu_E} !== 9'd0) begin
      n_err++; $display("FAIL reset_ctrl: got ready=%b rsp_valid=%b alu_E=%b, expected all 0", req_ready, rsp_valid, alu_E);
    end
    n_chk++;
    if ({rsp_data, rsp_flags, sr_flags, alu_Cflags, alu_Mode, alu_Operand1, alu_Operand2} !== 40'd0) begin
      n_err++; $display("FAIL reset_data: got data=%h flags=%b sr=%b mode=%h op1=%h op2=%h, expected 0",
                        rsp_data, rsp_flags, sr_flags, alu_Mode, alu_Operand1, alu_Operand2);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic_add();
    set_req(0, ALU_ADD, 8'h7F, 8'h01);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL add_ready: got %b expected 0001", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (alu_E !== 1'b1 || req_ready !== 4'b0 || alu_Operand1 !== 8'h7F || alu_Operand2 !== 8'h01) begin
      n_err++; $display("FAIL add_issue: got alu_E=%b ready=%b op1=%h op2=%h, expected 1 0000 7f 01", alu_E, req_ready, alu_Operand1, alu_Operand2);
    end
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 4'b0001 || alu_E !== 1'b0) begin
      n_err++; $display("FAIL add_resp: got rsp_valid=%b alu_E=%b, expected 0001 0", rsp_valid, alu_E);
    end
    n_chk++;
    if (rsp_data !== 8'h80 || rsp_flags !== 4'b0011 || sr_flags !== 4'b0011) begin
      n_err++; $display("FAIL add_result: got data=%h flags=%b sr=%b, expected 80 0011 0011", rsp_data, rsp_flags, sr_flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_zero();
    set_req(1, ALU_SUB, 8'h05, 8'h05);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0010) begin n_err++; $display("FAIL sub_ready: got %b expected 0010", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 8'h00 || rsp_flags !== 4'b1100 || sr_flags !== 4'b1100) begin
      n_err++; $display("FAIL sub_result: got valid=%b data=%h flags=%b sr=%b, expected 0010 00 1100 1100", rsp_valid, rsp_data, rsp_flags, sr_flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_carry_feedback();
    set_req(2, ALU_ADC, 8'h10, 8'h20);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0100) begin n_err++; $display("FAIL adc_ready: got %b expected 0100", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (alu_Cflags !== 4'b1100) begin n_err++; $display("FAIL adc_cflags: got %b expected 1100", alu_Cflags); end
    @(negedge clk);
    n_chk++;
    if (rsp_data !== 8'h31 || sr_flags !== 4'b0000) begin
      n_err++; $display("FAIL adc_result: got data=%h sr=%b, expected 31 0000", rsp_data, sr_flags);
    end
    @(posedge clk); #1;
    set_req(3, ALU_AND, 8'hF0, 8'h3C);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b1000) begin n_err++; $display("FAIL and_ready: got %b expected 1000", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    int t_prev;
    t_prev = 0;
    set_req(0, ALU_ADD, 8'h80, 8'h80);
    set_req(1, ALU_SUB, 8'h03, 8'h05);
    set_req(2, ALU_XOR, 8'hAA, 8'h55);
    set_req(3, ALU_ADC, 8'hFF, 8'h00);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (req_ready != 4'b0) break;
      end
      n_chk++;
      if (req_ready !== 4'b1 << (g % 4)) begin
        n_err++; $display("FAIL rr_grant%0d: got %b expected %b", g, req_ready, 4'b1 << (g % 4));
      end
      if (g > 0) begin
        n_chk++;
        if (cyc - t_prev !== 3) begin n_err++; $display("FAIL rr_spacing%0d: got %0d cycles expected 3", g, cyc - t_prev); end
      end
      t_prev = cyc;
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_back_pressure();
    rsp_ready = 4'b1101;
    set_req(1, ALU_ADD, 8'h01, 8'h02);
    set_req(2, ALU_SUB, 8'h09, 8'h03);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_ready: got %b expected 0010", req_ready); end
    @(posedge clk); #1 req_valid[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid != 4'b0) break;
    end
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (rsp_valid !== 4'b0010 || rsp_data !== 8'h03 || rsp_flags !== 4'b0000 || req_ready !== 4'b0 || alu_E !== 1'b0 || alu_Operand1 !== 8'h01) begin
        n_err++; $display("FAIL bp_hold%0d: got valid=%b data=%h flags=%b ready=%b alu_E=%b op1=%h, expected 0010 03 0000 0000 0 01",
                          k, rsp_valid, rsp_data, rsp_flags, req_ready, alu_E, alu_Operand1);
      end
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0) break;
    end
    n_chk++;
    if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_next: got %b expected 0100", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    set_req(3, ALU_ADD, 8'h11, 8'h22);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rmid_ready: got %b expected 1000", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (alu_E !== 1'b1) begin n_err++; $display("FAIL rmid_issue: got alu_E=%b expected 1", alu_E); end
    #1 rst_n = 1'b0;
    sb.delete();
    sr_exp = '0;
    #1;
    n_chk++;
    if ({req_ready, rsp_valid, alu_E, rsp_data, rsp_flags, sr_flags, alu_Mode, alu_Operand1, alu_Operand2} !== 45'd0) begin
      n_err++; $display("FAIL rmid_zero: got ready=%b valid=%b E=%b data=%h flags=%b sr=%b mode=%h op1=%h op2=%h, expected all 0",
                        req_ready, rsp_valid, alu_E, rsp_data, rsp_flags, sr_flags, alu_Mode, alu_Operand1, alu_Operand2);
    end
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    set_req(0, ALU_XOR, 8'h0F, 8'hF0);
    set_req(2, ALU_AND, 8'hFF, 8'h81);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rmid_first: got %b expected 0001", req_ready); end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0) break;
    end
    n_chk++;
    if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rmid_second: got %b expected 0100", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_lock();
    set_req(3, ALU_ADD, 8'h40, 8'h40);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b1000) begin n_err++; $display("FAIL lock_pre: got %b expected 1000", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    set_req(2, ALU_ADD, 8'h01, 8'h01);
    set_req(3, ALU_SUB, 8'h02, 8'h07);
    req_lock[2] = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0100) begin n_err++; $display("FAIL lock_first: got %b expected 0100", req_ready); end
    @(posedge clk); #1 req_lock[2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0) break;
    end
`ifdef ALU_ARB_LOCK_EN
    n_chk++;
    if (req_ready !== 4'b0100) begin n_err++; $display("FAIL lock_hold: got %b expected 0100", req_ready); end
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0) break;
    end
`endif
    n_chk++;
    if (req_ready !== 4'b1000) begin n_err++; $display("FAIL lock_next: got %b expected 1000", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_add();
    test_sub_zero();
    test_carry_feedback();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_op();
    test_lock();
    n_chk++;
    if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d outstanding expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
